// File: rtl/interrupt_controller.sv
// Four-source edge-triggered interrupt controller with fixed priority and an ack/done handshake.
// Optional preemption with a 3-entry level stack when INTC_NESTING_EN is defined.
module interrupt_controller #(
    parameter int NSRC = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        int0,
    input  logic        int1,
    input  logic        int2,
    input  logic        int3,
    input  logic        intWrite,
    input  logic [15:0] intDataIn,
    input  logic        intAck,
    input  logic        intDone,
    output logic        intr,
    output logic        intLvl1,
    output logic        intLvl0,
    output logic [15:0] intDataOut
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t            state_q, state_d;
    logic [NSRC-1:0]   prev_q, pend_q, pend_d, en_q;
    logic              gie_q;
    logic [1:0]        lvl_q, lvl_d;
    logic [15:0]       dout_q;
    logic [NSRC-1:0]   irq, rise, elig;
    logic [1:0]        win;
    logic              any_elig, ack_clr, nested;

    logic unused_din;
    assign unused_din = ^{intDataIn[15:12], intDataIn[7:5]};

    assign irq      = {int3, int2, int1, int0};
    assign rise     = irq & ~prev_q;
    assign elig     = pend_q & en_q & {NSRC{gie_q}};
    assign any_elig = |elig;

    // Lowest eligible index wins
    always_comb begin
        win = 2'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) win = 2'(i);
        end
    end

`ifdef INTC_NESTING_EN
    logic [1:0] stk_q [3];
    logic [1:0] sp_q;
    logic [1:0] sp_m1;
    logic       push, pop;

    assign sp_m1  = sp_q - 2'd1;
    assign nested = (sp_q != 2'd0);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sp_q <= 2'd0;
            for (int i = 0; i < 3; i++) stk_q[i] <= 2'd0;
        end else if (push) begin
            stk_q[sp_q] <= lvl_q;
            sp_q        <= sp_q + 2'd1;
        end else if (pop) begin
            sp_q <= sp_m1;
        end
    end
`else
    assign nested = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        ack_clr = 1'b0;
`ifdef INTC_NESTING_EN
        push    = 1'b0;
        pop     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    lvl_d   = win;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (intAck) begin
                    ack_clr = 1'b1;
                    state_d = SERVICE;
                end else if (!elig[lvl_q]) begin
                    // A withdrawn preempting request falls back to the interrupted level
`ifdef INTC_NESTING_EN
                    if (nested) begin
                        pop     = 1'b1;
                        lvl_d   = stk_q[sp_m1];
                        state_d = SERVICE;
                    end else begin
                        lvl_d   = 2'd0;
                        state_d = IDLE;
                    end
`else
                    lvl_d   = 2'd0;
                    state_d = IDLE;
`endif
                end
            end
            SERVICE: begin
                if (intDone) begin
`ifdef INTC_NESTING_EN
                    if (nested) begin
                        pop     = 1'b1;
                        lvl_d   = stk_q[sp_m1];
                    end else begin
                        lvl_d   = 2'd0;
                        state_d = IDLE;
                    end
`else
                    lvl_d   = 2'd0;
                    state_d = IDLE;
`endif
                end
`ifdef INTC_NESTING_EN
                else if (any_elig && (win < lvl_q)) begin
                    push    = 1'b1;
                    lvl_d   = win;
                    state_d = REQ;
                end
`endif
            end
            default: begin
                lvl_d   = 2'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Clears first, then new edges, so a same-cycle set wins
    always_comb begin
        pend_d = pend_q;
        if (intWrite) pend_d = pend_d & ~intDataIn[11:8];
        if (ack_clr)  pend_d[lvl_q] = 1'b0;
        pend_d = pend_d | rise;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            lvl_q   <= 2'd0;
            prev_q  <= '0;
            pend_q  <= '0;
            en_q    <= '0;
            gie_q   <= 1'b0;
            dout_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            prev_q  <= irq;
            pend_q  <= pend_d;
            if (intWrite) begin
                en_q  <= intDataIn[3:0];
                gie_q <= intDataIn[4];
            end
            dout_q  <= {nested, (state_q == SERVICE), lvl_q, pend_q, 3'b000, gie_q, en_q};
        end
    end

    assign intr       = (state_q == REQ);
    assign intLvl1    = lvl_q[1];
    assign intLvl0    = lvl_q[0];
    assign intDataOut = dout_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller; nesting scenario follows INTC_NESTING_EN.
module tb_interrupt_controller;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        int0, int1, int2, int3;
    logic        intWrite;
    logic [15:0] intDataIn;
    logic        intAck, intDone;
    logic        intr, intLvl1, intLvl0;
    logic [15:0] intDataOut;

    int checks = 0;
    int errors = 0;

    interrupt_controller #(.NSRC(4)) dut (
        .CLK(CLK), .Reset(Reset),
        .int0(int0), .int1(int1), .int2(int2), .int3(int3),
        .intWrite(intWrite), .intDataIn(intDataIn),
        .intAck(intAck), .intDone(intDone),
        .intr(intr), .intLvl1(intLvl1), .intLvl0(intLvl0),
        .intDataOut(intDataOut)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [15:0] d);
        intWrite = 1'b1; intDataIn = d;
        tick();
        intWrite = 1'b0; intDataIn = 16'h0;
    endtask

    task automatic ack();
        intAck = 1'b1; tick(); intAck = 1'b0;
    endtask

    task automatic done();
        intDone = 1'b1; tick(); intDone = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b0; int0 = 0; int1 = 0; int2 = 0; int3 = 0;
        intWrite = 0; intDataIn = 0; intAck = 0; intDone = 0;
        #12;
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({intr, intLvl1, intLvl0, intDataOut} !== 19'h0) begin
            errors++; $display("FAIL reset_outputs: got intr=%b lvl=%b%b dout=%h, want 0/00/0000", intr, intLvl1, intLvl0, intDataOut);
        end
    endtask

    task automatic test_basic();
        wr(16'h001F);
        int2 = 1; tick(); int2 = 0;
        checks++;
        if (intr !== 1'b0) begin errors++; $display("FAIL basic_latency: intr=%b want 0", intr); end
        tick();
        checks++;
        if ({intr, intLvl1, intLvl0} !== 3'b110) begin
            errors++; $display("FAIL basic_req: intr/lvl=%b want 110", {intr, intLvl1, intLvl0});
        end
        checks++;
        if (intDataOut !== 16'h041F) begin errors++; $display("FAIL basic_pend: dout=%h want 041F", intDataOut); end
        ack();
        checks++;
        if (intr !== 1'b0) begin errors++; $display("FAIL basic_ack: intr=%b want 0", intr); end
        tick();
        checks++;
        if (intDataOut !== 16'h601F) begin errors++; $display("FAIL basic_service: dout=%h want 601F", intDataOut); end
        done(); tick();
        checks++;
        if ({intr, intDataOut} !== 17'h0001F) begin
            errors++; $display("FAIL basic_done: intr=%b dout=%h want 0/001F", intr, intDataOut);
        end
    endtask

    task automatic test_priority();
        int1 = 1; int3 = 1; tick(); int1 = 0; int3 = 0;
        tick();
        checks++;
        if ({intr, intLvl1, intLvl0} !== 3'b101) begin
            errors++; $display("FAIL prio_first: intr/lvl=%b want 101", {intr, intLvl1, intLvl0});
        end
        ack(); done();
        checks++;
        if (intr !== 1'b0) begin errors++; $display("FAIL prio_gap: intr=%b want 0", intr); end
        tick();
        checks++;
        if ({intr, intLvl1, intLvl0} !== 3'b111) begin
            errors++; $display("FAIL prio_second: intr/lvl=%b want 111", {intr, intLvl1, intLvl0});
        end
        ack(); done(); tick();
    endtask

    task automatic test_gie();
        wr(16'h000F);
        int0 = 1; tick(); int0 = 0; tick();
        checks++;
        if ({intr, intDataOut} !== 17'h0010F) begin
            errors++; $display("FAIL gie_off: intr=%b dout=%h want 0/010F", intr, intDataOut);
        end
        wr(16'h001F);
        checks++;
        if (intr !== 1'b0) begin errors++; $display("FAIL gie_enable_lat: intr=%b want 0", intr); end
        tick();
        checks++;
        if ({intr, intLvl1, intLvl0} !== 3'b100) begin
            errors++; $display("FAIL gie_on: intr/lvl=%b want 100", {intr, intLvl1, intLvl0});
        end
        ack(); done();
        wr(16'h000F);
        int0 = 1; tick(); int0 = 0;
        wr(16'h011F);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (intr !== 1'b0) begin errors++; $display("FAIL w1c_no_intr: cycle %0d intr=%b want 0", i, intr); end
            tick();
        end
        checks++;
        if (intDataOut !== 16'h001F) begin errors++; $display("FAIL w1c_pend: dout=%h want 001F", intDataOut); end
    endtask

    task automatic test_withdraw();
        int2 = 1; tick(); int2 = 0; tick();
        checks++;
        if (intr !== 1'b1) begin errors++; $display("FAIL wd_req: intr=%b want 1", intr); end
        wr(16'h001B);
        checks++;
        if (intr !== 1'b1) begin errors++; $display("FAIL wd_hold: intr=%b want 1", intr); end
        tick();
        checks++;
        if (intr !== 1'b0) begin errors++; $display("FAIL wd_drop: intr=%b want 0", intr); end
        tick();
        checks++;
        if ({intr, intDataOut} !== 17'h0041B) begin
            errors++; $display("FAIL wd_pend: intr=%b dout=%h want 0/041B", intr, intDataOut);
        end
        wr(16'h041F); tick(); tick();
        checks++;
        if ({intr, intDataOut} !== 17'h0001F) begin
            errors++; $display("FAIL wd_cleanup: intr=%b dout=%h want 0/001F", intr, intDataOut);
        end
    endtask

    task automatic test_async_reset_and_stray();
        int3 = 1; tick(); int3 = 0; tick(); ack(); tick();
        checks++;
        if (intDataOut !== 16'h701F) begin errors++; $display("FAIL ar_service: dout=%h want 701F", intDataOut); end
        #2 Reset = 1'b0; #1;
        checks++;
        if ({intr, intLvl1, intLvl0, intDataOut} !== 19'h0) begin
            errors++; $display("FAIL ar_async: intr=%b lvl=%b%b dout=%h want all 0", intr, intLvl1, intLvl0, intDataOut);
        end
        tick(); Reset = 1'b1; tick();
        wr(16'h000F);
        int1 = 1; tick(); int1 = 0;
        ack(); done(); tick();
        checks++;
        if ({intr, intLvl1, intLvl0, intDataOut} !== {3'b000, 16'h020F}) begin
            errors++; $display("FAIL stray_hs: intr=%b lvl=%b%b dout=%h want 0/00/020F", intr, intLvl1, intLvl0, intDataOut);
        end
        wr(16'h021F); tick();
    endtask

    task automatic test_nesting();
        int3 = 1; tick(); int3 = 0; tick(); ack();
        int0 = 1; tick(); int0 = 0; tick();
`ifdef INTC_NESTING_EN
        checks++;
        if ({intr, intLvl1, intLvl0} !== 3'b100) begin
            errors++; $display("FAIL nest_preempt: intr/lvl=%b want 100", {intr, intLvl1, intLvl0});
        end
        tick();
        checks++;
        if (intDataOut[15] !== 1'b1) begin errors++; $display("FAIL nest_bit15: dout=%h want bit15=1", intDataOut); end
        ack(); done();
        checks++;
        if ({intr, intLvl1, intLvl0} !== 3'b011) begin
            errors++; $display("FAIL nest_pop: intr/lvl=%b want 011", {intr, intLvl1, intLvl0});
        end
        tick();
        checks++;
        if (intDataOut !== 16'h701F) begin errors++; $display("FAIL nest_restored: dout=%h want 701F", intDataOut); end
        done(); tick();
        checks++;
        if ({intr, intDataOut} !== 17'h0001F) begin
            errors++; $display("FAIL nest_idle: intr=%b dout=%h want 0/001F", intr, intDataOut);
        end
`else
        checks++;
        if ({intr, intLvl1, intLvl0} !== 3'b011) begin
            errors++; $display("FAIL nonest_hold: intr/lvl=%b want 011", {intr, intLvl1, intLvl0});
        end
        checks++;
        if (intDataOut !== 16'h711F) begin errors++; $display("FAIL nonest_pend: dout=%h want 711F", intDataOut); end
        done();
        checks++;
        if (intr !== 1'b0) begin errors++; $display("FAIL nonest_gap: intr=%b want 0", intr); end
        tick();
        checks++;
        if ({intr, intLvl1, intLvl0} !== 3'b100) begin
            errors++; $display("FAIL nonest_next: intr/lvl=%b want 100", {intr, intLvl1, intLvl0});
        end
        ack(); done(); tick();
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_gie();
        test_withdraw();
        test_async_reset_and_stray();
        test_nesting();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
